// File: rtl/sorter_pkg.sv
// Shared types and helpers for the sequential odd-even transposition sorter.
//   state_e          : controller states (idle / sorting / result held)
//   phase_cnt_width  : width of the phase counter for a given element count
//   DirAsc / DirDesc : encodings of the per-transaction sort direction
package sorter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSort,
    StDone
  } state_e;

  localparam logic DirAsc  = 1'b0;
  localparam logic DirDesc = 1'b1;

  // One extra bit so the counter can represent N itself without wrapping.
  function automatic int unsigned phase_cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sorter_cmp_swap.sv
// Single compare-exchange cell for the transposition network.
//   a_i, b_i      : elements at the lower / higher index of the pair
//   descending_i  : direction, DirDesc puts the larger value at the lower index
//   lo_o, hi_o    : elements to write back to the lower / higher index
//   swapped_o     : high when the pair was exchanged
// Equal elements never exchange, which keeps the sort stable.
module sorter_cmp_swap
  import sorter_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         descending_i,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] hi_o,
  output logic         swapped_o
);

  always_comb begin
    swapped_o = (descending_i == DirDesc) ? (a_i < b_i) : (a_i > b_i);
    lo_o      = swapped_o ? b_i : a_i;
    hi_o      = swapped_o ? a_i : b_i;
  end

endmodule

// File: rtl/param_seq_sorter.sv
// Sequential odd-even transposition sorter: N unsigned W-bit elements, one
// compare-exchange phase per clock, valid/ready on both sides.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : input handshake; in_data element i at [i*W +: W]
//   descending            : direction, sampled on accept
//   out_valid/out_ready   : output handshake; out_data holds the last result
//   busy                  : high while sorting
// Build option SORTER_EARLY_EXIT_EN: finish once two consecutive phases make
// no exchange; otherwise exactly N phases are always run.
module param_seq_sorter
  import sorter_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic         descending,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N*W-1:0] out_data,
  output logic         busy
);

  localparam int unsigned PW      = phase_cnt_width(N);
  localparam int unsigned NumEven = N / 2;
  localparam int unsigned NumOdd  = (N - 1) / 2;
  localparam int unsigned NumOddW = (NumOdd > 0) ? NumOdd : 1;

  state_e           state_q, state_d;
  logic [N*W-1:0]   elem_q, elem_d;
  logic [N*W-1:0]   out_q, out_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             desc_q, desc_d;

  logic [N*W-1:0]   even_vec, odd_vec, phase_vec;
  logic [NumEven-1:0] even_sw;
  logic [NumOddW-1:0] odd_sw;
  logic             phase_swap, last_phase, sort_done;

  // Even phases: pairs (0,1),(2,3),...
  for (genvar i = 0; i < NumEven; i++) begin : g_even
    sorter_cmp_swap #(.W(W)) u_cs (
      .a_i          (elem_q[2*i*W +: W]),
      .b_i          (elem_q[(2*i+1)*W +: W]),
      .descending_i (desc_q),
      .lo_o         (even_vec[2*i*W +: W]),
      .hi_o         (even_vec[(2*i+1)*W +: W]),
      .swapped_o    (even_sw[i])
    );
  end
  if (N % 2 == 1) begin : g_even_tail
    assign even_vec[(N-1)*W +: W] = elem_q[(N-1)*W +: W];
  end

  // Odd phases: pairs (1,2),(3,4),...; element 0 always passes through.
  for (genvar i = 0; i < NumOdd; i++) begin : g_odd
    sorter_cmp_swap #(.W(W)) u_cs (
      .a_i          (elem_q[(2*i+1)*W +: W]),
      .b_i          (elem_q[(2*i+2)*W +: W]),
      .descending_i (desc_q),
      .lo_o         (odd_vec[(2*i+1)*W +: W]),
      .hi_o         (odd_vec[(2*i+2)*W +: W]),
      .swapped_o    (odd_sw[i])
    );
  end
  if (NumOdd == 0) begin : g_odd_none
    assign odd_sw = '0;
  end
  assign odd_vec[0 +: W] = elem_q[0 +: W];
  if (N % 2 == 0) begin : g_odd_tail
    assign odd_vec[(N-1)*W +: W] = elem_q[(N-1)*W +: W];
  end

  assign phase_vec  = phase_q[0] ? odd_vec : even_vec;
  assign phase_swap = phase_q[0] ? |odd_sw : |even_sw;
  assign last_phase = (phase_q == PW'(N - 1));

`ifdef SORTER_EARLY_EXIT_EN
  // Remembers that the previously applied phase exchanged nothing.
  logic noswap_q, noswap_d;
  assign sort_done = last_phase || ((phase_q != '0) && noswap_q && !phase_swap);
`else
  logic unused_phase_swap;
  assign unused_phase_swap = phase_swap;
  assign sort_done         = last_phase;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StSort;
      StSort:  if (sort_done) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StSort);
    out_valid = (state_q == StDone);
    out_data  = out_q;
  end

  // Datapath next state
  always_comb begin
    elem_d  = elem_q;
    out_d   = out_q;
    phase_d = phase_q;
    desc_d  = desc_q;
`ifdef SORTER_EARLY_EXIT_EN
    noswap_d = noswap_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          elem_d  = in_data;
          desc_d  = descending;
          phase_d = '0;
`ifdef SORTER_EARLY_EXIT_EN
          noswap_d = 1'b0;
`endif
        end
      end
      StSort: begin
        elem_d  = phase_vec;
        phase_d = phase_q + PW'(1);
`ifdef SORTER_EARLY_EXIT_EN
        noswap_d = !phase_swap;
`endif
        if (sort_done) out_d = phase_vec;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      elem_q  <= '0;
      out_q   <= '0;
      phase_q <= '0;
      desc_q  <= DirAsc;
`ifdef SORTER_EARLY_EXIT_EN
      noswap_q <= 1'b0;
`endif
    end else begin
      elem_q  <= elem_d;
      out_q   <= out_d;
      phase_q <= phase_d;
      desc_q  <= desc_d;
`ifdef SORTER_EARLY_EXIT_EN
      noswap_q <= noswap_d;
`endif
    end
  end

endmodule

// File: tb/tb_param_seq_sorter.sv
// Directed, table-driven bench for param_seq_sorter (N=4/W=2 and N=5/W=8).
module tb_param_seq_sorter;

`ifdef SORTER_EARLY_EXIT_EN
  localparam int EeLat4 = 2;
  localparam int EeLat5 = 2;
`else
  localparam int EeLat4 = 4;
  localparam int EeLat5 = 5;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_desc, a_out_valid, a_out_ready, a_busy;
  logic [7:0]  a_in_data, a_out_data;
  logic        b_in_valid, b_in_ready, b_desc, b_out_valid, b_out_ready, b_busy;
  logic [39:0] b_in_data, b_out_data;

  param_seq_sorter #(.N(4), .W(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .descending(a_desc), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  param_seq_sorter #(.N(5), .W(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .descending(b_desc), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {e3[1:0], e2[1:0], e1[1:0], e0[1:0]};
  endfunction

  function automatic logic [39:0] pack5(input int e0, input int e1, input int e2, input int e3,
                                        input int e4);
    return {e4[7:0], e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
  endfunction

  // Reference: selection sort on unpacked elements.
  function automatic logic [7:0] ref4(input logic [7:0] d, input logic desc);
    int v[4];
    int t;
    for (int i = 0; i < 4; i++) v[i] = int'(d[i*2 +: 2]);
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (desc ? (v[j] > v[i]) : (v[j] < v[i])) begin
          t = v[i]; v[i] = v[j]; v[j] = t;
        end
    return pack4(v[0], v[1], v[2], v[3]);
  endfunction

  task automatic xfer4(input logic [7:0] d, input logic desc, output logic [7:0] res,
                       output int lat, output int bcnt);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = d; a_desc = desc;
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 0; bcnt = 0;
    while (!a_out_valid && lat < 20) begin
      if (a_busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check("a_out_valid_reached", 64'(a_out_valid), 64'(1));
    res = a_out_data;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic xfer5(input logic [39:0] d, input logic desc, output logic [39:0] res,
                       output int lat);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = d; b_desc = desc;
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b_out_valid_reached", 64'(b_out_valid), 64'(1));
    res = b_out_data;
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] din;
    logic       desc;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t        tbl[6];
  logic [7:0]  r4;
  logic [39:0] r5;
  int          lat, bcnt;

  initial begin
    tbl[0] = '{pack4(3, 1, 2, 0), 1'b0, pack4(0, 1, 2, 3), 4};
    tbl[1] = '{pack4(3, 1, 2, 0), 1'b1, pack4(3, 2, 1, 0), 4};
    tbl[2] = '{pack4(2, 2, 1, 1), 1'b0, pack4(1, 1, 2, 2), 4};
    tbl[3] = '{pack4(1, 1, 1, 1), 1'b0, pack4(1, 1, 1, 1), EeLat4};
    tbl[4] = '{pack4(0, 1, 2, 3), 1'b1, pack4(3, 2, 1, 0), 4};
    tbl[5] = '{pack4(0, 1, 2, 3), 1'b0, pack4(0, 1, 2, 3), EeLat4};

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_desc = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_desc = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  64'(a_in_ready), 64'(1));
    check("rst_out_valid", 64'(a_out_valid), 64'(0));
    check("rst_busy",      64'(a_busy), 64'(0));
    check("rst_out_data",  64'(a_out_data), 64'(0));
    check("rst_b_in_ready", 64'(b_in_ready), 64'(1));
    check("rst_b_out_data", 64'(b_out_data), 64'(0));
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      xfer4(tbl[i].din, tbl[i].desc, r4, lat, bcnt);
      check($sformatf("tbl%0d_data", i), 64'(r4), 64'(tbl[i].exp));
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("tbl%0d_busy_cycles", i), 64'(bcnt), 64'(tbl[i].lat));
    end

    // Backpressure: result held, pending input refused until after handshake.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = pack4(3, 1, 2, 0); a_desc = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_out_valid_reached", 64'(a_out_valid), 64'(1));
    a_in_valid = 1'b1; a_in_data = pack4(1, 0, 3, 2); a_desc = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid_held", 64'(a_out_valid), 64'(1));
      check("bp_out_data_held",  64'(a_out_data), 64'(pack4(0, 1, 2, 3)));
      check("bp_in_ready_low",   64'(a_in_ready), 64'(0));
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    check("bp_release_out_valid", 64'(a_out_valid), 64'(0));
    check("bp_release_in_ready",  64'(a_in_ready), 64'(1));
    check("bp_release_out_data",  64'(a_out_data), 64'(pack4(0, 1, 2, 3)));
    @(negedge clk);
    a_in_valid = 1'b0;
    check("bp_pending_accepted", 64'(a_busy), 64'(1));
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_pending_latency", 64'(lat), 64'(4));
    check("bp_pending_data", 64'(a_out_data), 64'(pack4(3, 2, 1, 0)));
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;

    // Reset while phase 2 is about to be applied.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = pack4(2, 3, 0, 1); a_desc = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy_before_rst", 64'(a_busy), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready",  64'(a_in_ready), 64'(1));
    check("mid_rst_out_valid", 64'(a_out_valid), 64'(0));
    check("mid_rst_busy",      64'(a_busy), 64'(0));
    check("mid_rst_out_data",  64'(a_out_data), 64'(0));
    rst_n = 1'b1;
    xfer4(pack4(2, 3, 0, 1), 1'b0, r4, lat, bcnt);
    check("post_rst_data", 64'(r4), 64'(pack4(0, 1, 2, 3)));

    // N=5, W=8: odd element count
    xfer5(pack5(200, 7, 7, 255, 0), 1'b0, r5, lat);
    check("n5_asc_data", 64'(r5), 64'(pack5(0, 7, 7, 200, 255)));
    check("n5_asc_latency", 64'(lat), 64'(5));
    xfer5(pack5(200, 7, 7, 255, 0), 1'b1, r5, lat);
    check("n5_desc_data", 64'(r5), 64'(pack5(255, 200, 7, 7, 0)));
    xfer5(pack5(1, 2, 3, 4, 5), 1'b0, r5, lat);
    check("n5_sorted_data", 64'(r5), 64'(pack5(1, 2, 3, 4, 5)));
    check("n5_sorted_latency", 64'(lat), 64'(EeLat5));

    // Exhaustive N=4 sweep against the reference model.
    for (int d = 0; d < 256; d++) begin
      for (int s = 0; s < 2; s++) begin
        xfer4(8'(d), 1'(s), r4, lat, bcnt);
        check($sformatf("sweep_%0h_%0d", d, s), 64'(r4), 64'(ref4(8'(d), 1'(s))));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
